// File: rtl/control_unit_pkg.sv
// control_pkg: opcodes, IR field positions, FSM state codes (the step output
// reports these), opcode classes, and the strobe bundle driven by control_unit.
package control_pkg;

  localparam int unsigned IR_W   = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned STEP_W = 4;

  // Instruction register field positions
  localparam int unsigned IR_OP_MSB = 31;
  localparam int unsigned IR_OP_LSB = 27;
  localparam int unsigned IR_RA_MSB = 26;
  localparam int unsigned IR_RA_LSB = 23;
  localparam int unsigned IR_RB_MSB = 22;
  localparam int unsigned IR_RB_LSB = 19;
  localparam int unsigned IR_RC_MSB = 18;
  localparam int unsigned IR_RC_LSB = 15;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11000;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11001;

  typedef enum logic [STEP_W-1:0] {
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_UNARY, CL_MULDIV, CL_HALT
  } op_class_e;

  typedef struct packed {
    logic pci, pco, iri, iro, mari, maro, mdri, mdro;
    logic hii, hio, loi, loo, ryi, ryo, rzi, rzo, rzhio;
    logic mem_read, mem_write;
    logic csigno, gra, grb, grc, rin, rout, baout;
  } strobes_t;

  // Map an opcode onto the execute sequence it shares with its group
  function automatic op_class_e classify(input logic [OPC_W-1:0] op);
    op_class_e cls;
    cls = CL_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:       cls = CL_IMM;
      OP_LDI:                         cls = CL_LDI;
      OP_LD:                          cls = CL_LD;
      OP_ST:                          cls = CL_ST;
      OP_NEG, OP_NOT:                 cls = CL_UNARY;
      OP_MUL, OP_DIV:                 cls = CL_MULDIV;
      OP_HALT:                        cls = CL_HALT;
      OP_NOP:                         cls = CL_NOP;
      default:                        cls = CL_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: control bundle between control_unit (master) and the
// datapath (slave).
//   ir            datapath -> control   instruction register contents
//   pc_immediate  control  -> datapath  PC load value (valid while pci)
//   strobes       control  -> datapath  register / memory / select strobes
//   halted, step  control  -> datapath  status and debug state code
interface control_unit_if;

  logic [control_pkg::IR_W-1:0]   ir;
  logic [control_pkg::PC_W-1:0]   pc_immediate;
  logic pci, pco, iri, iro, mari, maro, mdri, mdro;
  logic hii, hio, loi, loo, ryi, ryo, rzi, rzo, rzhio;
  logic mem_read, mem_write;
  logic csigno, gra, grb, grc, rin, rout, baout;
  logic                           halted;
  logic [control_pkg::STEP_W-1:0] step;

  modport master (
    input  ir,
    output pc_immediate,
    output pci, pco, iri, iro, mari, maro, mdri, mdro,
    output hii, hio, loi, loo, ryi, ryo, rzi, rzo, rzhio,
    output mem_read, mem_write,
    output csigno, gra, grb, grc, rin, rout, baout,
    output halted, step
  );

  modport slave (
    output ir,
    input  pc_immediate,
    input  pci, pco, iri, iro, mari, maro, mdri, mdro,
    input  hii, hio, loi, loo, ryi, ryo, rzi, rzo, rzhio,
    input  mem_read, mem_write,
    input  csigno, gra, grb, grc, rin, rout, baout,
    input  halted, step
  );

endinterface

// File: rtl/control_unit_pc_shadow.sv
// pc_shadow: 32-bit shadow program counter, increments when inc_en_i is high.
//   clock     rising-edge clock
//   clear     asynchronous active-low clear (count returns to 0)
//   inc_en_i  increment enable
//   count_o   current count (wraps 0xFFFFFFFF -> 0)
module pc_shadow
  import control_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic            inc_en_i,
  output logic [PC_W-1:0] count_o
);

  logic [PC_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_en_i) count_d = count_q + PC_W'(1);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore sequencing FSM. Three-cycle fetch (T0-T2) followed by an
// opcode-specific execute sequence (T3-T7); HALT is left only through clear.
//   clock  rising-edge clock
//   clear  asynchronous active-low reset (state -> T0, pc_shadow -> 0)
//   cu     control_unit_if.master: ir in; pc_immediate, strobes, halted, step out
// Build option: define MULDIV_EN to enable the mul/div sequence; otherwise
// mul/div execute as nop and hii/loi/rzhio stay 0.
module control_unit
  import control_pkg::*;
(
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master cu
);

`ifdef MULDIV_EN
  localparam bit MULDIV_ON = 1'b1;
`else
  localparam bit MULDIV_ON = 1'b0;
`endif

  state_e          state_q, state_d;
  op_class_e       cls_c;
  strobes_t        strb_c;
  logic [PC_W-1:0] pc_q;
  logic            unused_ir;

  // Register fields are decoded by the datapath, not here
  assign unused_ir = ^{cu.ir[IR_RA_MSB:IR_RA_LSB], cu.ir[IR_RB_MSB:IR_RB_LSB],
                       cu.ir[IR_RC_MSB:IR_RC_LSB], cu.ir[IR_RC_LSB-1:0]};

  // Opcode class; mul/div fall back to nop when the unit is not built
  always_comb begin
    cls_c = classify(cu.ir[IR_OP_MSB:IR_OP_LSB]);
    if (cls_c == CL_MULDIV && !MULDIV_ON) cls_c = CL_NOP;
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_T0: state_d = ST_T1;
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        case (cls_c)
          CL_HALT: state_d = ST_HALT;
          CL_NOP:  state_d = ST_T0;
          default: state_d = ST_T4;
        endcase
      end
      ST_T4: state_d = ST_T5;
      ST_T5: state_d = (cls_c inside {CL_LD, CL_ST, CL_MULDIV}) ? ST_T6 : ST_T0;
      ST_T6: state_d = (cls_c == CL_MULDIV) ? ST_T0 : ST_T7;
      ST_T7: state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= ST_T0;
    else        state_q <= state_d;
  end

  // Moore strobe decode: depends on state (and the held IR from T3 on) only,
  // so clear removes any in-flight strobe immediately
  always_comb begin
    strb_c = '0;
    case (state_q)
      ST_T0: begin strb_c.pco = 1'b1; strb_c.mari = 1'b1; strb_c.pci = 1'b1; end
      ST_T1: begin strb_c.mem_read = 1'b1; strb_c.mdri = 1'b1; end
      ST_T2: begin strb_c.mdro = 1'b1; strb_c.iri = 1'b1; end
      ST_T3: begin
        case (cls_c)
          CL_ALU, CL_IMM, CL_UNARY: begin
            strb_c.grb = 1'b1; strb_c.rout = 1'b1; strb_c.ryi = 1'b1;
          end
          CL_LDI, CL_LD, CL_ST: begin
            strb_c.grb = 1'b1; strb_c.baout = 1'b1; strb_c.ryi = 1'b1;
          end
          CL_MULDIV: begin
            strb_c.gra = 1'b1; strb_c.rout = 1'b1; strb_c.ryi = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls_c)
          CL_ALU: begin strb_c.grc = 1'b1; strb_c.rout = 1'b1; strb_c.rzi = 1'b1; end
          CL_IMM, CL_LDI, CL_LD, CL_ST: begin strb_c.csigno = 1'b1; strb_c.rzi = 1'b1; end
          CL_UNARY: strb_c.rzi = 1'b1;
          CL_MULDIV: begin strb_c.grb = 1'b1; strb_c.rout = 1'b1; strb_c.rzi = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        strb_c.rzo = 1'b1;
        case (cls_c)
          CL_LD, CL_ST: strb_c.mari = 1'b1;
          CL_MULDIV:    strb_c.loi = 1'b1;
          default: begin strb_c.gra = 1'b1; strb_c.rin = 1'b1; end
        endcase
      end
      ST_T6: begin
        case (cls_c)
          CL_LD: begin strb_c.mem_read = 1'b1; strb_c.mdri = 1'b1; end
          // mem_read low: MDR takes the register value from the bus
          CL_ST: begin strb_c.gra = 1'b1; strb_c.rout = 1'b1; strb_c.mdri = 1'b1; end
          CL_MULDIV: begin strb_c.rzhio = 1'b1; strb_c.hii = 1'b1; end
          default: ;
        endcase
      end
      ST_T7: begin
        if (cls_c == CL_ST) strb_c.mem_write = 1'b1;
        else begin strb_c.mdro = 1'b1; strb_c.gra = 1'b1; strb_c.rin = 1'b1; end
      end
      default: ;
    endcase
  end

  pc_shadow u_pc_shadow (
    .clock    (clock),
    .clear    (clear),
    .inc_en_i (state_q == ST_T0),
    .count_o  (pc_q)
  );

  assign cu.pc_immediate = pc_q + PC_W'(1);
  assign cu.halted       = (state_q == ST_HALT);
  assign cu.step         = state_q;

  assign cu.pci       = strb_c.pci;
  assign cu.pco       = strb_c.pco;
  assign cu.iri       = strb_c.iri;
  assign cu.iro       = strb_c.iro;
  assign cu.mari      = strb_c.mari;
  assign cu.maro      = strb_c.maro;
  assign cu.mdri      = strb_c.mdri;
  assign cu.mdro      = strb_c.mdro;
  assign cu.hii       = strb_c.hii;
  assign cu.hio       = strb_c.hio;
  assign cu.loi       = strb_c.loi;
  assign cu.loo       = strb_c.loo;
  assign cu.ryi       = strb_c.ryi;
  assign cu.ryo       = strb_c.ryo;
  assign cu.rzi       = strb_c.rzi;
  assign cu.rzo       = strb_c.rzo;
  assign cu.rzhio     = strb_c.rzhio;
  assign cu.mem_read  = strb_c.mem_read;
  assign cu.mem_write = strb_c.mem_write;
  assign cu.csigno    = strb_c.csigno;
  assign cu.gra       = strb_c.gra;
  assign cu.grb       = strb_c.grb;
  assign cu.grc       = strb_c.grc;
  assign cu.rin       = strb_c.rin;
  assign cu.rout      = strb_c.rout;
  assign cu.baout     = strb_c.baout;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit. The stimulus process
// pushes one expected entry per clock cycle of each instruction (built from
// per-opcode strobe tables); the monitor pops and compares on each falling
// edge, or immediately when an asynchronous clear is being checked.
`timescale 1ns/1ps
module tb_control_unit;
  import control_pkg::*;

  localparam int NS = 26;
  localparam int S_PCI = 0, S_PCO = 1, S_IRI = 2, S_IRO = 3, S_MARI = 4, S_MARO = 5;
  localparam int S_MDRI = 6, S_MDRO = 7, S_HII = 8, S_HIO = 9, S_LOI = 10, S_LOO = 11;
  localparam int S_RYI = 12, S_RYO = 13, S_RZI = 14, S_RZO = 15, S_RZHIO = 16;
  localparam int S_MRD = 17, S_MWR = 18, S_CSIGNO = 19, S_GRA = 20, S_GRB = 21;
  localparam int S_GRC = 22, S_RIN = 23, S_ROUT = 24, S_BAOUT = 25;
  localparam int HALT_CYCLES = 20;

  typedef struct {
    logic [NS-1:0] strb;
    logic [3:0]    step;
    logic          halted;
    bit            chk_pc;
    logic [31:0]   pc;
    int            tag;
    int            idx;
  } exp_t;

  exp_t        exp_q[$];
  logic        clock = 1'b0;
  logic        clear = 1'b1;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] pc_model = 32'd0;
  logic [3:0]  tcode[8];
  event        sample_now;

  control_unit_if cu();

  control_unit dut (
    .clock (clock),
    .clear (clear),
    .cu    (cu)
  );

  always #5 clock = ~clock;

  initial begin
    tcode = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7};
  end

  function automatic logic [NS-1:0] mk(input int a = -1, input int b = -1, input int c = -1);
    logic [NS-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [NS-1:0] dut_vec();
    logic [NS-1:0] v;
    v = '0;
    v[S_PCI] = cu.pci;     v[S_PCO] = cu.pco;     v[S_IRI] = cu.iri;     v[S_IRO] = cu.iro;
    v[S_MARI] = cu.mari;   v[S_MARO] = cu.maro;   v[S_MDRI] = cu.mdri;   v[S_MDRO] = cu.mdro;
    v[S_HII] = cu.hii;     v[S_HIO] = cu.hio;     v[S_LOI] = cu.loi;     v[S_LOO] = cu.loo;
    v[S_RYI] = cu.ryi;     v[S_RYO] = cu.ryo;     v[S_RZI] = cu.rzi;     v[S_RZO] = cu.rzo;
    v[S_RZHIO] = cu.rzhio; v[S_MRD] = cu.mem_read; v[S_MWR] = cu.mem_write;
    v[S_CSIGNO] = cu.csigno; v[S_GRA] = cu.gra;   v[S_GRB] = cu.grb;     v[S_GRC] = cu.grc;
    v[S_RIN] = cu.rin;     v[S_ROUT] = cu.rout;   v[S_BAOUT] = cu.baout;
    return v;
  endfunction

  // Reference model: per-cycle strobe list for one instruction, pushed to the scoreboard
  function automatic void push_instr(input logic [31:0] instr, input int tag,
                                     input int max_entries, output int cnt);
    logic [NS-1:0] seq[$];
    logic [4:0]    op;
    bit            halts;
    exp_t          e;
    op    = instr[31:27];
    halts = 1'b0;
    seq   = {};
    seq.push_back(mk(S_PCO, S_MARI, S_PCI));
    seq.push_back(mk(S_MRD, S_MDRI));
    seq.push_back(mk(S_MDRO, S_IRI));
    if (op inside {[5'd3:5'd10]}) begin
      seq.push_back(mk(S_GRB, S_ROUT, S_RYI));
      seq.push_back(mk(S_GRC, S_ROUT, S_RZI));
      seq.push_back(mk(S_RZO, S_GRA, S_RIN));
    end else if (op inside {5'd11, 5'd12, 5'd13}) begin
      seq.push_back(mk(S_GRB, S_ROUT, S_RYI));
      seq.push_back(mk(S_CSIGNO, S_RZI));
      seq.push_back(mk(S_RZO, S_GRA, S_RIN));
    end else if (op == 5'd1) begin
      seq.push_back(mk(S_GRB, S_BAOUT, S_RYI));
      seq.push_back(mk(S_CSIGNO, S_RZI));
      seq.push_back(mk(S_RZO, S_GRA, S_RIN));
    end else if (op == 5'd0 || op == 5'd2) begin
      seq.push_back(mk(S_GRB, S_BAOUT, S_RYI));
      seq.push_back(mk(S_CSIGNO, S_RZI));
      seq.push_back(mk(S_RZO, S_MARI));
      if (op == 5'd0) begin
        seq.push_back(mk(S_MRD, S_MDRI));
        seq.push_back(mk(S_MDRO, S_GRA, S_RIN));
      end else begin
        seq.push_back(mk(S_GRA, S_ROUT, S_MDRI));
        seq.push_back(mk(S_MWR));
      end
    end else if (op == 5'd16 || op == 5'd17) begin
      seq.push_back(mk(S_GRB, S_ROUT, S_RYI));
      seq.push_back(mk(S_RZI));
      seq.push_back(mk(S_RZO, S_GRA, S_RIN));
`ifdef MULDIV_EN
    end else if (op == 5'd14 || op == 5'd15) begin
      seq.push_back(mk(S_GRA, S_ROUT, S_RYI));
      seq.push_back(mk(S_GRB, S_ROUT, S_RZI));
      seq.push_back(mk(S_RZO, S_LOI));
      seq.push_back(mk(S_RZHIO, S_HII));
`endif
    end else begin
      seq.push_back('0);
      halts = (op == 5'd25);
    end
    cnt = 0;
    foreach (seq[i]) begin
      if (cnt < max_entries) begin
        e.strb = seq[i]; e.step = tcode[i]; e.halted = 1'b0;
        e.chk_pc = (i == 0); e.pc = pc_model + 32'd1;
        e.tag = tag; e.idx = i;
        exp_q.push_back(e);
        cnt++;
      end
    end
    pc_model = pc_model + 32'd1;
    if (halts) begin
      for (int k = 0; k < HALT_CYCLES; k++) begin
        e.strb = '0; e.step = ST_HALT; e.halted = 1'b1; e.chk_pc = 1'b0;
        e.pc = '0; e.tag = tag; e.idx = 4 + k;
        exp_q.push_back(e);
        cnt++;
      end
    end
  endfunction

  function automatic void push_reset(input int tag);
    exp_t e;
    e.strb = mk(S_PCO, S_MARI, S_PCI); e.step = ST_T0; e.halted = 1'b0;
    e.chk_pc = 1'b1; e.pc = 32'd1; e.tag = tag; e.idx = -1;
    exp_q.push_back(e);
  endfunction

  task automatic run(input logic [31:0] instr, input int tag);
    int cnt;
    cu.ir = instr;
    push_instr(instr, tag, 1000, cnt);
    repeat (cnt) @(posedge clock);
    #1;
  endtask

  // Monitor: invariants every sample, scoreboard compare when an entry is due
  initial begin
    exp_t        e;
    logic [NS-1:0] got;
    int          drivers;
    forever begin
      @(negedge clock or sample_now);
      drivers = int'(cu.pco) + int'(cu.mdro) + int'(cu.rout) + int'(cu.baout) + int'(cu.rzo)
              + int'(cu.rzhio) + int'(cu.csigno) + int'(cu.iro) + int'(cu.maro)
              + int'(cu.hio) + int'(cu.loo) + int'(cu.ryo);
      n_tests++;
      if (drivers > 1) begin
        n_fail++;
        $display("FAIL bus_drivers t=%0t got=%0d max=1", $time, drivers);
      end
      n_tests++;
      if (cu.mem_read === 1'b1 && cu.mem_write === 1'b1) begin
        n_fail++;
        $display("FAIL mem_rd_wr t=%0t both high", $time);
      end
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = dut_vec();
        n_tests++;
        if (got !== e.strb) begin
          n_fail++;
          $display("FAIL strobes tag=%0d idx=%0d got=%b want=%b", e.tag, e.idx, got, e.strb);
        end
        n_tests++;
        if (cu.step !== e.step) begin
          n_fail++;
          $display("FAIL step tag=%0d idx=%0d got=%0d want=%0d", e.tag, e.idx, cu.step, e.step);
        end
        n_tests++;
        if (cu.halted !== e.halted) begin
          n_fail++;
          $display("FAIL halted tag=%0d idx=%0d got=%b want=%b", e.tag, e.idx, cu.halted, e.halted);
        end
        if (e.chk_pc) begin
          n_tests++;
          if (cu.pc_immediate !== e.pc) begin
            n_fail++;
            $display("FAIL pc_immediate tag=%0d got=%h want=%h", e.tag, cu.pc_immediate, e.pc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [31:0] instr;
    logic [4:0]  op;
    int          cnt;
    cu.ir = '0;
    #1 clear = 1'b0;
    #2 push_reset(0);
    -> sample_now;
    @(posedge clock); #1 clear = 1'b1; pc_model = 32'd0;

    run(32'h18918000, 1);                            // add r1,r2,r3 (pc_imm=1)
    run(32'h18918000, 2);                            // second T0 shows pc_imm=2
    run({5'b00000, 27'($urandom)}, 3);               // ld
    run({5'b00010, 27'($urandom)}, 4);               // st
    run(32'h70900000, 5);                            // mul
    run({5'b01111, 27'($urandom)}, 6);               // div
    run({5'b11000, 27'd0}, 7);                       // nop

    for (int n = 0; n < 150; n++) begin
      do op = 5'($urandom_range(31)); while (op == 5'b11001);
      instr = {op, 27'($urandom)};
      run(instr, 100 + n);
    end

    // Clear during ld T6: strobes must fall at once, no write afterwards
    instr = {5'b00000, 27'($urandom)};
    cu.ir = instr;
    push_instr(instr, 50, 7, cnt);
    repeat (6) @(posedge clock);
    @(negedge clock);
    #2 clear = 1'b0;
    #1 push_reset(51);
    -> sample_now;
    @(posedge clock); #1 clear = 1'b1; pc_model = 32'd0;
    run({5'b00010, 27'($urandom)}, 52);

    // Halt holds for HALT_CYCLES, then clear restarts fetch at pc_imm=1
    run(32'hC8000000, 60);
    clear = 1'b0;
    #1 push_reset(61);
    -> sample_now;
    @(posedge clock); #1 clear = 1'b1; pc_model = 32'd0;
    run(32'h18918000, 62);

    repeat (2) @(negedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-style sequencing FSM that sits directly upstream of the datapath and drives every one of its control strobes. It steps each instruction through a three-cycle fetch (T0–T2) and an opcode-specific execute sequence (T3–T7), reading the opcode from the instruction register contents fed back from the datapath. It also maintains the shadow program counter that supplies the datapath's PC load value.

## Interface
- Parameters: none (opcodes and states live in the package).
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- ir  in  32  instruction register contents: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- pc_immediate  out  32  PC load value, valid while pci is high.
- pci, pco, iri, iro, mari, maro, mdri, mdro  out  1 each  register strobes.
- hii, hio, loi, loo, ryi, ryo, rzi, rzo, rzhio  out  1 each  register strobes:
  - rzo drives rz_lo onto the bus.
  - rzhio drives rz_hi onto the bus.
- mem_read, mem_write  out  1 each  memory strobes.
- csigno, gra, grb, grc, rin, rout, baout  out  1 each  select/encode strobes.
- halted  out  1  high while in HALT.
- step  out  4  current state code, for debug.

## Operation
- Sequencing:
  - Outputs are decoded combinationally from the registered state only; `ir` is sampled in T3 and later.
  - Any strobe not listed for a state is 0.
- Fetch, shared by all instructions:
  - T0: pco, mari, pci. pc_immediate = pc_shadow+1; pc_shadow increments at the end of T0.
  - T1: mem_read, mdri.
  - T2: mdro, iri.
- ALU reg-reg (add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010):
  - T3: grb, rout, ryi.
  - T4: grc, rout, rzi.
  - T5: rzo, gra, rin. Then T0.
- Immediate (addi 01011, andi 01100, ori 01101):
  - T3: grb, rout, ryi.
  - T4: csigno, rzi.
  - T5: rzo, gra, rin.
- ldi 00001: T3 grb, baout, ryi; T4 csigno, rzi; T5 rzo, gra, rin.
- ld 00000:
  - T3–T5 as ldi, except T5 is rzo, mari.
  - T6: mem_read, mdri.
  - T7: mdro, gra, rin.
- st 00010:
  - T3–T5 as ld.
  - T6: gra, rout, mdri (mem_read=0, so MDR loads from the bus).
  - T7: mem_write.
- Unary (neg 10000, not 10001): T3 grb, rout, ryi; T4 rzi; T5 rzo, gra, rin.
- mul 01110, div 01111:
  - T3: gra, rout, ryi.
  - T4: grb, rout, rzi.
  - T5: rzo, loi.
  - T6: rzhio, hii.
- nop 11000, and any unlisted opcode: T3 with no strobes, then T0.
- halt 11001: T3 → HALT. HALT asserts halted, drives no strobes, and is exited only by reset.

## Timing
- Reset (clear=0), asynchronous:
  - State goes to T0 and pc_shadow to 0.
  - Strobes are decoded from T0, so pco, mari and pci read 1 during reset; all other strobes, halted and step read 0. pc_immediate reads 1.
  - A reset mid-instruction abandons the sequence; no partial write completes after clear falls.
- Cycle counts including fetch: reg-reg/imm/ldi/unary 6, ld/st 8, mul/div 7, nop 4.
- pc_shadow wraps from 0xFFFFFFFF to 0.
- At most one bus driver is active in any state.
- mem_read and mem_write are never high together.

## Configuration
- MULDIV_EN defined: mul and div run the T3–T6 sequence.
- MULDIV_EN undefined: opcodes 01110 and 01111 decode as nop (4 cycles). hii and loi are tied to 0; rzhio is tied to 0 (only mul/div drive it).

## Structure
- Package control_pkg holds:
  - the opcode localparams (5-bit);
  - the state encoding T0–T7 plus HALT as 4-bit codes; step equals this code;
  - field bit positions.
- One sub-module, pc_shadow: 32-bit counter with increment enable and async active-low clear.

## Test plan
- Reset, then release: first cycle shows step=T0, pco=mari=pci=1, pc_immediate=1. Next T0 shows pc_immediate=2.
- ir=0x18918000 (add r1,r2,r3):
  - T3 grb|rout|ryi, T4 grc|rout|rzi, T5 rzo|gra|rin.
  - Back to T0 after 6 cycles.
- ld then st: st T6 asserts mdri with mem_read=0; T7 asserts only mem_write. ld totals 8 cycles.
- ir=0x70900000 (mul):
  - With MULDIV_EN: T5 rzo|loi, T6 rzhio|hii.
  - Without it: 4 cycles, no strobes in T3.
- ir=0xC8000000: halted=1 from the cycle after T3 and stays high with zero strobes for 20 cycles. Pulsing clear returns to T0 with pc_immediate=1.
- Assert clear during ld T6: mdri drops asynchronously and step=T0. No mem_write is ever asserted.
